// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback handshake bundle.
// Stage side is slave; the producer/consumer side is master.
interface alu_wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_flags;
    logic [3:0]  in_rd;
    logic        in_wr_en;
    logic        in_set_flags;
    logic [3:0]  in_cond;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_rd;
    logic        out_wr_en;

    modport slave (
        input  in_valid, in_data, in_flags, in_rd,
        input  in_wr_en, in_set_flags, in_cond,
        input  flush, out_ready,
        output in_ready, out_valid, out_data,
        output out_rd, out_wr_en
    );

    modport master (
        output in_valid, in_data, in_flags, in_rd,
        output in_wr_en, in_set_flags, in_cond,
        output flush, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_rd, out_wr_en
    );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: condition check, APSR update, skip counter
// and a small in-order output FIFO toward the register file.
module alu_wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_wb_stage_if.slave      bus,
    output logic [3:0]         apsr_nzcv,
    output logic [15:0]        skip_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        wr_en;
    } wb_ent_t;

    wb_ent_t       r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_apsr;
    logic [15:0]   r_skip;

    logic    w_ready;
    logic    w_accept;
    logic    w_pop;
    logic    w_pass;
    logic    w_nonempty;
    wb_ent_t w_head;

    function automatic logic cond_pass(
        input logic [3:0] c,
        input logic [3:0] f
    );
        logic n, z, cy, v;
        logic res;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: res = z;
            4'b0001: res = !z;
            4'b0010: res = cy;
            4'b0011: res = !cy;
            4'b0100: res = n;
            4'b0101: res = !n;
            4'b0110: res = v;
            4'b0111: res = !v;
            4'b1000: res = cy & !z;
            4'b1001: res = !cy | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = !z & (n == v);
            4'b1101: res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // ready is a pure function of occupancy, never of out_ready
    assign w_ready    = !rst && (r_cnt < FULL);
    assign w_accept   = bus.in_valid && w_ready && !bus.flush;
    assign w_nonempty = (r_cnt != '0);
    assign w_pop      = w_nonempty && bus.out_ready;
    assign w_pass     = cond_pass(bus.in_cond, r_apsr);
    assign w_head     = w_nonempty ? r_mem[r_rptr] : '0;

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_nonempty;
    assign bus.out_data  = w_head.data;
    assign bus.out_rd    = w_head.rd;
    assign bus.out_wr_en = w_head.wr_en;
    assign apsr_nzcv     = r_apsr;
    assign skip_cnt      = r_skip;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= '{
                data:  bus.in_data,
                rd:    bus.in_rd,
                wr_en: bus.in_wr_en & w_pass
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_apsr <= 4'b0000;
            r_skip <= 16'h0000;
        end else if (w_accept) begin
            if (w_pass && bus.in_set_flags) begin
                r_apsr <= bus.in_flags;
            end
            if (!w_pass && r_skip != 16'hFFFF) begin
                r_skip <= r_skip + 16'h0001;
            end
        end
    end
endmodule
